// File: rtl/tt_sweep.sv
// Truth-table sweeper: drives every 4-bit vector onto {a,b,c,d}, waits SETTLE
// cycles per vector, and captures f into a 16-bit table with a running popcount.
module tt_sweep #(
   parameter int unsigned SETTLE = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic        a,
   output logic        b,
   output logic        c,
   output logic        d,
   input  logic        f,
   output logic        busy,
   output logic        done,
   output logic [15:0] tt,
   output logic        tt_valid,
   output logic [4:0]  ones
);

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      SAMPLE,
      DONE
   } state_t;

   localparam logic [3:0] SCNT_LAST = 4'(SETTLE - 1);

   state_t     state;
   logic [3:0] idx;
   logic [3:0] scnt;
   logic [3:0] vec;

   assign {a, b, c, d} = vec;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         idx      <= '0;
         scnt     <= '0;
         vec      <= '0;
         tt       <= '0;
         ones     <= '0;
         tt_valid <= 1'b0;
         done     <= 1'b0;
         busy     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               vec <= '0;
               if (start) begin
                  tt       <= '0;
                  ones     <= '0;
                  tt_valid <= 1'b0;
                  idx      <= '0;
                  scnt     <= '0;
                  busy     <= 1'b1;
                  state    <= WAIT;
               end
            end
            WAIT: begin
               vec  <= idx;
               scnt <= scnt + 4'd1;
               if (scnt == SCNT_LAST) state <= SAMPLE;
            end
            SAMPLE: begin
               tt[idx] <= f;
               ones    <= ones + 5'(f);
               // the next vector is presented on the same edge, so the
               // applied value changes only once per SETTLE+1 cycles
               if (idx == 4'd15) begin
                  vec      <= '0;
                  busy     <= 1'b0;
                  done     <= 1'b1;
                  tt_valid <= 1'b1;
                  state    <= DONE;
               end else begin
                  idx   <= idx + 4'd1;
                  vec   <= idx + 4'd1;
                  scnt  <= '0;
                  state <= WAIT;
               end
            end
            DONE: begin
               vec   <= '0;
               state <= IDLE;
            end
            default: begin
               vec   <= '0;
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tt_sweep.sv
// Scoreboard bench for tt_sweep: two instances (SETTLE=1 and SETTLE=3), each
// sweep pushes its expected table/popcount/done cycle, a monitor pops on done.
module tb_tt_sweep;

   typedef struct {
      logic [15:0] tt;
      logic [4:0]  ones;
      int          done_cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0;
   logic [1:0] mode = 2'd0;
   int sel = 1;
   int cyc = 0;
   int checks = 0;
   int errors = 0;
   exp_t q1[$];
   exp_t q3[$];

   logic a1, b1, c1, d1, f1, busy1, done1, tt_valid1;
   logic [15:0] tt1;
   logic [4:0]  ones1;
   logic a3, b3, c3, d3, f3, busy3, done3, tt_valid3;
   logic [15:0] tt3;
   logic [4:0]  ones3;
   logic start1, start3;

   logic [3:0]  m_abcd;
   logic        m_busy, m_done, m_valid;
   logic [15:0] m_tt;
   logic [4:0]  m_ones;

   function automatic logic fm(input logic [1:0] m, input logic [3:0] v);
      case (m)
         2'd0:    fm = &v;
         2'd1:    fm = v[0];
         2'd2:    fm = v[3];
         default: fm = 1'b1;
      endcase
   endfunction

   assign f1 = fm(mode, {a1, b1, c1, d1});
   assign f3 = fm(mode, {a3, b3, c3, d3});
   assign start1 = start && (sel == 1);
   assign start3 = start && (sel == 3);

   assign m_abcd  = (sel == 3) ? {a3, b3, c3, d3} : {a1, b1, c1, d1};
   assign m_busy  = (sel == 3) ? busy3 : busy1;
   assign m_done  = (sel == 3) ? done3 : done1;
   assign m_valid = (sel == 3) ? tt_valid3 : tt_valid1;
   assign m_tt    = (sel == 3) ? tt3 : tt1;
   assign m_ones  = (sel == 3) ? ones3 : ones1;

   tt_sweep #(.SETTLE(1)) dut1 (
      .clk(clk), .rst(rst), .start(start1),
      .a(a1), .b(b1), .c(c1), .d(d1), .f(f1),
      .busy(busy1), .done(done1), .tt(tt1), .tt_valid(tt_valid1), .ones(ones1)
   );

   tt_sweep #(.SETTLE(3)) dut3 (
      .clk(clk), .rst(rst), .start(start3),
      .a(a3), .b(b3), .c(c3), .d(d3), .f(f3),
      .busy(busy3), .done(done3), .tt(tt3), .tt_valid(tt_valid3), .ones(ones3)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic mon_one(input int id, input logic dn, input logic bz, input logic [15:0] t,
                          input logic [4:0] o, input logic v, input logic [3:0] ab);
      exp_t e;
      if (dn) begin
         if ((id == 1 && q1.size() == 0) || (id == 3 && q3.size() == 0)) begin
            checks++;
            errors++;
            $display("FAIL done_unexpected: dut%0d got done=1 expected 0 (cycle %0d)", id, cyc);
         end else begin
            if (id == 1) e = q1.pop_front();
            else         e = q3.pop_front();
            chk($sformatf("tt_dut%0d", id), 32'(t), 32'(e.tt));
            chk($sformatf("ones_dut%0d", id), 32'(o), 32'(e.ones));
            chk($sformatf("tt_valid_at_done_dut%0d", id), 32'(v), 32'd1);
            chk($sformatf("done_cycle_dut%0d", id), cyc, e.done_cyc);
            chk($sformatf("busy_with_done_dut%0d", id), 32'(bz), 32'd0);
            chk($sformatf("abcd_in_done_dut%0d", id), 32'(ab), 32'd0);
         end
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_busy"}, 32'(m_busy), 32'd0);
      chk({tag, "_done"}, 32'(m_done), 32'd0);
      chk({tag, "_tt"}, 32'(m_tt), 32'h0);
      chk({tag, "_ones"}, 32'(m_ones), 32'd0);
      chk({tag, "_tt_valid"}, 32'(m_valid), 32'd0);
      chk({tag, "_abcd"}, 32'(m_abcd), 32'd0);
   endtask

   // restart_at / abort_at: loop index at which to re-pulse start or to reset (-1 = never)
   task automatic run_sweep(input int s, input logic [1:0] m, input logic [15:0] ett,
                            input logic [4:0] eones, input int restart_at, input int abort_at);
      exp_t e;
      int   e0;
      int   span;
      bit   got;
      span = 16 * (s + 1);
      @(negedge clk);
      sel   = s;
      mode  = m;
      start = 1'b1;
      e0    = cyc + 1;
      e.tt = ett;
      e.ones = eones;
      e.done_cyc = e0 + span;
      if (s == 1) q1.push_back(e);
      else        q3.push_back(e);
      @(negedge clk);
      start = 1'b0;
      chk("tt_valid_cleared", 32'(m_valid), 32'd0);
      chk("tt_cleared", 32'(m_tt), 32'h0);
      chk("ones_cleared", 32'(m_ones), 32'd0);
      for (int k = 0; k < span; k++) begin
         if (k > 0) @(negedge clk);
         start = (k == restart_at);
         if (k == abort_at) begin
            rst   = 1'b1;
            start = 1'b1;
            if (s == 1) q1.delete();
            else        q3.delete();
            @(negedge clk);
            rst   = 1'b0;
            start = 1'b0;
            chk_reset_vals("abort");
            repeat (40) @(negedge clk);
            chk("abort_no_restart_busy", 32'(m_busy), 32'd0);
            chk("abort_tt_valid", 32'(m_valid), 32'd0);
            return;
         end
         chk($sformatf("abcd_k%0d", k), 32'(m_abcd), 32'(k / (s + 1)));
         chk($sformatf("busy_k%0d", k), 32'(m_busy), 32'd1);
      end
      start = 1'b0;
      got = 1'b0;
      for (int w = 0; w < 10 && !got; w++) begin
         @(negedge clk);
         got = (s == 1) ? (q1.size() == 0) : (q3.size() == 0);
      end
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL done_timeout: got no done expected done by cycle %0d", e0 + span);
      end
      repeat (5) @(negedge clk);
      chk("hold_tt", 32'(m_tt), 32'(ett));
      chk("hold_ones", 32'(m_ones), 32'(eones));
      chk("hold_tt_valid", 32'(m_valid), 32'd1);
      chk("hold_abcd", 32'(m_abcd), 32'd0);
      chk("hold_busy", 32'(m_busy), 32'd0);
   endtask

   initial begin
      fork
         begin
            repeat (3) @(negedge clk);
            rst = 1'b0;
            sel = 1;
            chk_reset_vals("reset1");
            sel = 3;
            chk_reset_vals("reset3");
            run_sweep(1, 2'd0, 16'h8000, 5'd1, -1, -1);
            run_sweep(1, 2'd1, 16'hAAAA, 5'd8, -1, -1);
            run_sweep(1, 2'd2, 16'hFF00, 5'd8, 10, -1);
            run_sweep(1, 2'd1, 16'hAAAA, 5'd8, -1, -1);
            run_sweep(1, 2'd3, 16'hFFFF, 5'd16, -1, 20);
            run_sweep(3, 2'd3, 16'hFFFF, 5'd16, -1, -1);
            run_sweep(3, 2'd0, 16'h8000, 5'd1, -1, -1);
            repeat (5) @(negedge clk);
         end
         forever begin
            @(negedge clk);
            mon_one(1, done1, busy1, tt1, ones1, tt_valid1, {a1, b1, c1, d1});
            mon_one(3, done3, busy3, tt3, ones3, tt_valid3, {a3, b3, c3, d3});
         end
         begin
            #200000;
            $display("FAIL watchdog: got timeout expected completion (cycle %0d)", cyc);
            $fatal(1, "watchdog expired");
         end
      join_any
      disable fork;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
